// File: rtl/timer_sched.sv
// Timer scheduler: decodes CPU accesses onto a shared device bus for two timers,
// latches timer IRQs into pending bits and re-arms expired timers automatically.
module timer_sched #(
    parameter logic [31:0] T0_BASE    = 32'h0000_7F00,
    parameter logic [31:0] T1_BASE    = 32'h0000_7F10,
    parameter logic [31:0] SCH_BASE   = 32'h0000_7F20,
    parameter logic [31:0] REARM_CTRL = 32'h0000_0009
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic [3:0]  dev_addr,
    output logic [31:0] dev_wdata,
    output logic        t0_we,
    output logic        t1_we,
    input  logic [31:0] t0_rdata,
    input  logic [31:0] t1_rdata,
    input  logic        t0_irq,
    input  logic        t1_irq,
    output logic [5:0]  hwint
);

    typedef enum logic [2:0] {IDLE, P0, C0, P1, C1} state_t;

    state_t      state, state_n;
    logic [31:0] reload0, reload1;
    logic [3:0]  cfg;
    logic [1:0]  pend, req, irq_q;
    logic [1:0]  rise, req_clr, pend_clr;
    logic        t0_hit, t1_hit, sch_hit, sch_we;
    logic [31:0] sch_rdata;

    assign t0_hit  = (cpu_addr[31:4] == T0_BASE[31:4]);
    assign t1_hit  = (cpu_addr[31:4] == T1_BASE[31:4]);
    assign sch_hit = (cpu_addr[31:4] == SCH_BASE[31:4]);
    assign sch_we  = cpu_we & sch_hit;

    assign rise     = {t1_irq, t0_irq} & ~irq_q;
    assign req_clr  = {state == C1, state == C0};
    assign pend_clr = (sch_we && cpu_addr[3:2] == 2'd3) ? cpu_wdata[1:0] : 2'b00;

    // A new edge in the same cycle as a clear (W1C or CTRL write) wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            irq_q   <= '0;
            pend    <= '0;
            req     <= '0;
            cfg     <= '0;
            reload0 <= '0;
            reload1 <= '0;
        end else begin
            state <= state_n;
            irq_q <= {t1_irq, t0_irq};
            pend  <= (pend & ~pend_clr) | rise;
            req   <= (req & ~req_clr) | (rise & cfg[1:0]);
            if (sch_we) begin
                case (cpu_addr[3:2])
                    2'd0:    reload0 <= cpu_wdata;
                    2'd1:    reload1 <= cpu_wdata;
                    2'd2:    cfg     <= cpu_wdata[3:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_n   = state;
        dev_addr  = cpu_addr[3:0];
        dev_wdata = cpu_wdata;
        t0_we     = cpu_we & t0_hit;
        t1_we     = cpu_we & t1_hit;
        cpu_stall = 1'b0;
        if (state != IDLE) begin
            t0_we     = 1'b0;
            t1_we     = 1'b0;
            cpu_stall = t0_hit | t1_hit;
        end
        case (state)
            IDLE: begin
                if (req[0])      state_n = P0;
                else if (req[1]) state_n = P1;
            end
            P0: begin
                dev_addr  = 4'h4;
                dev_wdata = reload0;
                t0_we     = 1'b1;
                state_n   = C0;
            end
            C0: begin
                dev_addr  = 4'h0;
                dev_wdata = REARM_CTRL;
                t0_we     = 1'b1;
                state_n   = req[1] ? P1 : IDLE;
            end
            P1: begin
                dev_addr  = 4'h4;
                dev_wdata = reload1;
                t1_we     = 1'b1;
                state_n   = C1;
            end
            C1: begin
                dev_addr  = 4'h0;
                dev_wdata = REARM_CTRL;
                t1_we     = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Reset gates the bus outputs combinationally so strobes drop at once.
        if (!reset) begin
            dev_addr  = '0;
            dev_wdata = '0;
            t0_we     = 1'b0;
            t1_we     = 1'b0;
            cpu_stall = 1'b0;
        end
    end

    always_comb begin
        case (cpu_addr[3:2])
            2'd0:    sch_rdata = reload0;
            2'd1:    sch_rdata = reload1;
            2'd2:    sch_rdata = {28'd0, cfg};
            default: sch_rdata = {30'd0, pend};
        endcase
        if (cpu_stall)    cpu_rdata = '0;
        else if (t0_hit)  cpu_rdata = t0_rdata;
        else if (t1_hit)  cpu_rdata = t1_rdata;
        else if (sch_hit) cpu_rdata = sch_rdata;
        else              cpu_rdata = '0;
    end

    assign hwint = {4'b0000, pend[1] & cfg[3], pend[0] & cfg[2]};

endmodule

// File: tb/tb_timer_sched.sv
// Testbench for timer_sched: decode table, hand-written re-arm sequences, and
// randomized traffic checked against a queue-based bus-operation model.
module tb_timer_sched;

    localparam logic [31:0] T0_BASE  = 32'h0000_7F00;
    localparam logic [31:0] T1_BASE  = 32'h0000_7F10;
    localparam logic [31:0] SCH_BASE = 32'h0000_7F20;
    localparam logic [31:0] T0R      = 32'hA5A5_0001;
    localparam logic [31:0] T1R      = 32'h5A5A_0002;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dev_wdata, t0_rdata, t1_rdata;
    logic        cpu_we, cpu_stall, t0_we, t1_we, t0_irq, t1_irq;
    logic [3:0]  dev_addr;
    logic [5:0]  hwint;

    int n_cmp = 0;
    int n_err = 0;

    timer_sched #(
        .T0_BASE(T0_BASE), .T1_BASE(T1_BASE), .SCH_BASE(SCH_BASE), .REARM_CTRL(32'h0000_0009)
    ) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .t0_we(t0_we), .t1_we(t1_we), .t0_rdata(t0_rdata), .t1_rdata(t1_rdata),
        .t0_irq(t0_irq), .t1_irq(t1_irq), .hwint(hwint)
    );

    always #5 clk = ~clk;

    // Reference model: pending/request bits plus a queue of device-bus writes
    // the sequencer still owes (one entry per cycle of bus ownership).
    typedef struct { bit t; bit ctrl; } op_t;
    op_t         q[$];
    logic [31:0] m_reload [2];
    logic [3:0]  m_cfg;
    logic [1:0]  m_pend, m_req, m_prev;

    always @(posedge clk or negedge reset) begin
        logic [1:0] irq_now, rise, mask, old_req;
        bit busy;
        op_t cur;
        if (!reset) begin
            q.delete();
            m_reload[0] = '0; m_reload[1] = '0;
            m_cfg = '0; m_pend = '0; m_req = '0; m_prev = '0;
        end else begin
            irq_now = {t1_irq, t0_irq};
            rise    = irq_now & ~m_prev;
            m_prev  = irq_now;
            old_req = m_req;
            busy    = (q.size() != 0);
            cur     = '{t: 1'b0, ctrl: 1'b0};
            if (busy) begin
                cur = q[0];
                if (cur.ctrl) m_req[cur.t] = 1'b0;
            end
            m_req = m_req | (rise & m_cfg[1:0]);
            mask = 2'b00;
            if (cpu_we && cpu_addr[31:4] == SCH_BASE[31:4]) begin
                case (cpu_addr[3:2])
                    2'd0: m_reload[0] = cpu_wdata;
                    2'd1: m_reload[1] = cpu_wdata;
                    2'd2: m_cfg = cpu_wdata[3:0];
                    default: mask = cpu_wdata[1:0];
                endcase
            end
            m_pend = (m_pend & ~mask) | rise;
            if (busy) begin
                void'(q.pop_front());
                if (cur.ctrl && !cur.t && old_req[1]) begin
                    q.push_back('{t: 1'b1, ctrl: 1'b0});
                    q.push_back('{t: 1'b1, ctrl: 1'b1});
                end
            end else if (old_req[0]) begin
                q.push_back('{t: 1'b0, ctrl: 1'b0});
                q.push_back('{t: 1'b0, ctrl: 1'b1});
            end else if (old_req[1]) begin
                q.push_back('{t: 1'b1, ctrl: 1'b0});
                q.push_back('{t: 1'b1, ctrl: 1'b1});
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_check();
        logic t0h, t1h, sh, e_st, e_t0, e_t1;
        logic [3:0]  e_da;
        logic [31:0] e_wd, e_rd, s_rd;
        op_t cur;
        t0h = cpu_addr[31:4] == T0_BASE[31:4];
        t1h = cpu_addr[31:4] == T1_BASE[31:4];
        sh  = cpu_addr[31:4] == SCH_BASE[31:4];
        if (q.size() != 0) begin
            cur  = q[0];
            e_da = cur.ctrl ? 4'h0 : 4'h4;
            e_wd = cur.ctrl ? 32'h9 : m_reload[cur.t];
            e_t0 = !cur.t;
            e_t1 = cur.t;
            e_st = t0h | t1h;
        end else begin
            e_da = cpu_addr[3:0];
            e_wd = cpu_wdata;
            e_t0 = cpu_we & t0h;
            e_t1 = cpu_we & t1h;
            e_st = 1'b0;
        end
        case (cpu_addr[3:2])
            2'd0: s_rd = m_reload[0];
            2'd1: s_rd = m_reload[1];
            2'd2: s_rd = {28'd0, m_cfg};
            default: s_rd = {30'd0, m_pend};
        endcase
        e_rd = e_st ? 32'd0 : t0h ? t0_rdata : t1h ? t1_rdata : sh ? s_rd : 32'd0;
        chk("rnd_stall", 32'(cpu_stall), 32'(e_st));
        chk("rnd_rdata", cpu_rdata, e_rd);
        chk("rnd_dev_addr", 32'(dev_addr), 32'(e_da));
        chk("rnd_dev_wdata", dev_wdata, e_wd);
        chk("rnd_t0_we", 32'(t0_we), 32'(e_t0));
        chk("rnd_t1_we", 32'(t1_we), 32'(e_t1));
        chk("rnd_hwint", 32'(hwint), {30'd0, m_pend[1] & m_cfg[3], m_pend[0] & m_cfg[2]});
    endtask

    task automatic set_cpu(input logic [31:0] a, input logic w, input logic [31:0] d);
        cpu_addr = a; cpu_we = w; cpu_wdata = d;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic sch_wr(input logic [3:0] off, input logic [31:0] d);
        set_cpu(SCH_BASE + 32'(off), 1'b1, d);
        step();
        set_cpu('0, 1'b0, '0);
    endtask

    typedef struct {
        logic [31:0] addr; logic we; logic [31:0] wdata;
        logic [31:0] e_rd; logic [3:0] e_da; logic e_t0; logic e_t1;
    } vec_t;

    typedef struct { logic t0; logic t1; logic [3:0] da; logic [31:0] wd; } bus_t;

    initial begin
        vec_t vt[17];
        bus_t bt[5];
        vt[0]  = '{T0_BASE + 32'h8,  1'b0, 32'h0,         T0R,           4'h8, 1'b0, 1'b0};
        vt[1]  = '{T0_BASE + 32'h4,  1'b1, 32'h5,         T0R,           4'h4, 1'b1, 1'b0};
        vt[2]  = '{T1_BASE,          1'b1, 32'h9,         T1R,           4'h0, 1'b0, 1'b1};
        vt[3]  = '{T1_BASE + 32'hC,  1'b0, 32'h0,         T1R,           4'hC, 1'b0, 1'b0};
        vt[4]  = '{T0_BASE + 32'hF,  1'b1, 32'h3,         T0R,           4'hF, 1'b1, 1'b0};
        vt[5]  = '{32'h0000_7F30,    1'b1, 32'h7,         32'h0,         4'h0, 1'b0, 1'b0};
        vt[6]  = '{32'h0000_7EFC,    1'b1, 32'h7,         32'h0,         4'hC, 1'b0, 1'b0};
        vt[7]  = '{SCH_BASE,         1'b1, 32'h1234_5678, 32'h0,         4'h0, 1'b0, 1'b0};
        vt[8]  = '{SCH_BASE,         1'b0, 32'h0,         32'h1234_5678, 4'h0, 1'b0, 1'b0};
        vt[9]  = '{SCH_BASE + 32'h4, 1'b1, 32'hDEAD_BEEF, 32'h0,         4'h4, 1'b0, 1'b0};
        vt[10] = '{SCH_BASE + 32'h4, 1'b0, 32'h0,         32'hDEAD_BEEF, 4'h4, 1'b0, 1'b0};
        vt[11] = '{SCH_BASE + 32'h8, 1'b1, 32'hFFFF_FFF0, 32'h0,         4'h8, 1'b0, 1'b0};
        vt[12] = '{SCH_BASE + 32'h8, 1'b0, 32'h0,         32'h0,         4'h8, 1'b0, 1'b0};
        vt[13] = '{SCH_BASE + 32'h8, 1'b1, 32'hC,         32'h0,         4'h8, 1'b0, 1'b0};
        vt[14] = '{SCH_BASE + 32'h8, 1'b0, 32'h0,         32'hC,         4'h8, 1'b0, 1'b0};
        vt[15] = '{SCH_BASE + 32'hC, 1'b0, 32'h0,         32'h0,         4'hC, 1'b0, 1'b0};
        vt[16] = '{32'h0001_7F00,    1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 1'b0};

        reset = 1'b0; t0_irq = 0; t1_irq = 0; t0_rdata = T0R; t1_rdata = T1R;
        set_cpu(T0_BASE + 32'h4, 1'b1, 32'h5);
        step();
        #1;
        chk("rst_t0_we", 32'(t0_we), 0);
        chk("rst_dev_addr", 32'(dev_addr), 0);
        chk("rst_dev_wdata", dev_wdata, 0);
        chk("rst_stall", 32'(cpu_stall), 0);
        chk("rst_hwint", 32'(hwint), 0);
        step();
        set_cpu('0, 1'b0, '0);
        reset = 1'b1;

        // Decode table (bus idle, no IRQ activity)
        for (int unsigned i = 0; i < 17; i++) begin
            set_cpu(vt[i].addr, vt[i].we, vt[i].wdata);
            #1;
            chk($sformatf("vec%0d_rdata", i), cpu_rdata, vt[i].e_rd);
            chk($sformatf("vec%0d_dev_addr", i), 32'(dev_addr), 32'(vt[i].e_da));
            chk($sformatf("vec%0d_dev_wdata", i), dev_wdata, vt[i].wdata);
            chk($sformatf("vec%0d_t0_we", i), 32'(t0_we), 32'(vt[i].e_t0));
            chk($sformatf("vec%0d_t1_we", i), 32'(t1_we), 32'(vt[i].e_t1));
            chk($sformatf("vec%0d_stall", i), 32'(cpu_stall), 0);
            step();
        end
        set_cpu('0, 1'b0, '0);

        // Single timer 0 re-arm with CPU stalled during C0
        sch_wr(4'h0, 32'd5);
        sch_wr(4'h8, 32'h5);
        t0_irq = 1'b1;
        #1 chk("a_hwint_pre", 32'(hwint), 0);
        step(); #1;
        chk("a_hwint", 32'(hwint), 32'h1);
        chk("a_idle_t0_we", 32'(t0_we), 0);
        step(); #1;
        chk("a_p0_t0_we", 32'(t0_we), 1);
        chk("a_p0_addr", 32'(dev_addr), 4);
        chk("a_p0_data", dev_wdata, 5);
        step();
        set_cpu(T0_BASE + 32'h8, 1'b0, '0);
        t0_rdata = 32'hCAFE_0008;
        #1;
        chk("a_c0_stall", 32'(cpu_stall), 1);
        chk("a_c0_rdata", cpu_rdata, 0);
        chk("a_c0_addr", 32'(dev_addr), 0);
        chk("a_c0_data", dev_wdata, 9);
        chk("a_c0_t0_we", 32'(t0_we), 1);
        step(); #1;
        chk("a_idle_stall", 32'(cpu_stall), 0);
        chk("a_idle_rdata", cpu_rdata, 32'hCAFE_0008);
        chk("a_idle_we", 32'(t0_we), 0);
        set_cpu('0, 1'b0, '0);
        t0_irq = 1'b0;
        step();

        // Simultaneous edges: P0, C0, P1, C1 back-to-back, then idle
        sch_wr(4'h4, 32'h77);
        sch_wr(4'h8, 32'hF);
        sch_wr(4'hC, 32'h3);
        t0_irq = 1'b1; t1_irq = 1'b1;
        step();
        set_cpu(SCH_BASE + 32'hC, 1'b0, '0);
        #1;
        chk("b_pend", cpu_rdata, 3);
        chk("b_hwint", 32'(hwint), 3);
        chk("b_idle_we", 32'({t1_we, t0_we}), 0);
        set_cpu('0, 1'b0, '0);
        bt[0] = '{1'b1, 1'b0, 4'h4, 32'h5};
        bt[1] = '{1'b1, 1'b0, 4'h0, 32'h9};
        bt[2] = '{1'b0, 1'b1, 4'h4, 32'h77};
        bt[3] = '{1'b0, 1'b1, 4'h0, 32'h9};
        bt[4] = '{1'b0, 1'b0, 4'h0, 32'h0};
        for (int unsigned i = 0; i < 5; i++) begin
            step(); #1;
            chk($sformatf("b%0d_t0_we", i), 32'(t0_we), 32'(bt[i].t0));
            chk($sformatf("b%0d_t1_we", i), 32'(t1_we), 32'(bt[i].t1));
            chk($sformatf("b%0d_addr", i), 32'(dev_addr), 32'(bt[i].da));
            chk($sformatf("b%0d_data", i), dev_wdata, bt[i].wd);
        end

        // W1C of PEND0 in the same cycle as a new t0 edge: set wins
        t0_irq = 1'b0;
        step();
        t0_irq = 1'b1;
        set_cpu(SCH_BASE + 32'hC, 1'b1, 32'h1);
        step();
        set_cpu(SCH_BASE + 32'hC, 1'b0, '0);
        #1 chk("c_set_wins", cpu_rdata, 3);
        step();
        set_cpu(SCH_BASE + 32'hC, 1'b1, 32'h2);
        step();
        set_cpu(SCH_BASE + 32'hC, 1'b0, '0);
        #1;
        chk("c_w1c_pend", cpu_rdata, 1);
        chk("c_w1c_hwint", 32'(hwint), 1);
        chk("c_sch_nostall", 32'(cpu_stall), 0);
        set_cpu('0, 1'b0, '0);
        repeat (3) step();

        // Reset asserted during P1
        sch_wr(4'h8, 32'h2);
        t1_irq = 1'b0;
        step();
        t1_irq = 1'b1;
        step();
        step(); #1;
        chk("d_p1_t1_we", 32'(t1_we), 1);
        chk("d_p1_data", dev_wdata, 32'h77);
        #2 reset = 1'b0;
        #1;
        chk("d_rst_t1_we", 32'(t1_we), 0);
        chk("d_rst_addr", 32'(dev_addr), 0);
        chk("d_rst_hwint", 32'(hwint), 0);
        t1_irq = 1'b0; t0_irq = 1'b0;
        step();
        reset = 1'b1;
        set_cpu(SCH_BASE + 32'hC, 1'b0, '0);
        #1 chk("d_pend_cleared", cpu_rdata, 0);
        for (int unsigned i = 0; i < 3; i++) begin
            step(); #1;
            chk($sformatf("d_post%0d_we", i), 32'({t1_we, t0_we}), 0);
            chk($sformatf("d_post%0d_hwint", i), 32'(hwint), 0);
        end

        // Masks and auto-reload off: pending only, no bus writes
        t1_irq = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            step(); #1;
            chk($sformatf("e%0d_pend", i), cpu_rdata, 2);
            chk($sformatf("e%0d_hwint", i), 32'(hwint), 0);
            chk($sformatf("e%0d_we", i), 32'({t1_we, t0_we}), 0);
        end
        set_cpu('0, 1'b0, '0);
        step();

        // Randomized traffic against the reference model
        for (int unsigned i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 3))
                0: cpu_addr = T0_BASE + 32'($urandom_range(0, 15));
                1: cpu_addr = T1_BASE + 32'($urandom_range(0, 15));
                2: cpu_addr = SCH_BASE + 32'({$urandom_range(0, 3), 2'b00});
                default: cpu_addr = 32'h1000_0000 | 32'($urandom_range(0, 255));
            endcase
            cpu_we    = ($urandom_range(0, 3) == 0);
            cpu_wdata = $urandom;
            t0_rdata  = $urandom;
            t1_rdata  = $urandom;
            if ($urandom_range(0, 5) == 0) t0_irq = ~t0_irq;
            if ($urandom_range(0, 5) == 0) t1_irq = ~t1_irq;
            #1 model_check();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
